// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM controller: button-arbitration states and
// the default timing constants used by the generator's top level.
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INC_HOLD = 2'd1,
        DEC_HOLD = 2'd2,
        LOCKOUT  = 2'd3
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYCLES     = 2_000_000;
    localparam int DEF_REPEAT_DELAY_CYCLES = 50_000_000;
    localparam int DEF_REPEAT_RATE_CYCLES  = 25_000_000;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a counting debouncer: a new level is
// accepted only after it has been seen for DEBOUNCE_CYCLES consecutive cycles.
module button_debounce
    import pwm_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            // Any sample that agrees with the stable level restarts the count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_button_conditioner.sv
// Turns the two raw duty-adjust buttons into single-cycle step commands with
// auto-repeat while held; pressing both buttons locks out all commands.
module pwm_button_conditioner
    import pwm_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic increase_btn,
    input  logic decrease_btn,
    output logic duty_inc_pulse,
    output logic duty_dec_pulse,
    output logic inc_level,
    output logic dec_level
);

    localparam int DW = cnt_width(REPEAT_DELAY_CYCLES);
    localparam int RW = cnt_width(REPEAT_RATE_CYCLES);
    localparam int TW = (DW > RW) ? DW : RW;

    localparam logic [TW-1:0] DELAY_LOAD = TW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [TW-1:0] RATE_LOAD  = TW'(REPEAT_RATE_CYCLES - 1);

    btn_state_t    state;
    btn_state_t    state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic          inc_next;
    logic          dec_next;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn   (increase_btn),
        .level (inc_level)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn   (decrease_btn),
        .level (dec_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            timer          <= '0;
            duty_inc_pulse <= 1'b0;
            duty_dec_pulse <= 1'b0;
        end else begin
            state          <= state_next;
            timer          <= timer_next;
            duty_inc_pulse <= inc_next;
            duty_dec_pulse <= dec_next;
        end
    end

    // Release is tested before repeat expiry so a release landing on the
    // expiry cycle yields no pulse.
    always_comb begin
        state_next = state;
        timer_next = timer;
        inc_next   = 1'b0;
        dec_next   = 1'b0;
        case (state)
            IDLE: begin
                if (inc_level && dec_level) begin
                    state_next = LOCKOUT;
                end else if (inc_level) begin
                    inc_next   = 1'b1;
                    timer_next = DELAY_LOAD;
                    state_next = INC_HOLD;
                end else if (dec_level) begin
                    dec_next   = 1'b1;
                    timer_next = DELAY_LOAD;
                    state_next = DEC_HOLD;
                end
            end
            INC_HOLD: begin
                if (!inc_level) begin
                    state_next = IDLE;
                end else if (dec_level) begin
                    state_next = LOCKOUT;
                end else if (timer == '0) begin
                    inc_next   = 1'b1;
                    timer_next = RATE_LOAD;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            DEC_HOLD: begin
                if (!dec_level) begin
                    state_next = IDLE;
                end else if (inc_level) begin
                    state_next = LOCKOUT;
                end else if (timer == '0) begin
                    dec_next   = 1'b1;
                    timer_next = RATE_LOAD;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            LOCKOUT: begin
                if (!inc_level && !dec_level) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_button_conditioner.sv
// Directed bench for pwm_button_conditioner with short timing parameters;
// expected pulses are queued by cycle stamp and matched by a monitor.
module tb_pwm_button_conditioner;
    import pwm_ctrl_pkg::*;

    localparam int W = 33;

    logic clk;
    logic rst;
    logic increase_btn;
    logic decrease_btn;
    logic duty_inc_pulse;
    logic duty_dec_pulse;
    logic inc_level;
    logic dec_level;

    logic [31:0]  cyc;
    logic [W-1:0] exp_q[$];
    int           checks;
    int           errors;

    pwm_button_conditioner #(
        .DEBOUNCE_CYCLES     (4),
        .REPEAT_DELAY_CYCLES (10),
        .REPEAT_RATE_CYCLES  (5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .increase_btn   (increase_btn),
        .decrease_btn   (decrease_btn),
        .duty_inc_pulse (duty_inc_pulse),
        .duty_dec_pulse (duty_dec_pulse),
        .inc_level      (inc_level),
        .dec_level      (dec_level)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = '0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_pulse(input logic is_dec, input logic [31:0] at);
        exp_q.push_back({is_dec, at});
    endtask

    task automatic drain(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // scoreboard monitor: every pulse seen must match the head of the queue
    always @(negedge clk) begin
        if (!rst && (duty_inc_pulse || duty_dec_pulse)) begin
            logic [W-1:0] e;
            if (duty_inc_pulse && duty_dec_pulse) begin
                check("both_pulses", 32'd1, 32'd0);
            end else if (exp_q.size() == 0) begin
                check("unexpected_pulse_at_cycle", cyc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {31'd0, duty_dec_pulse}, {31'd0, e[32]});
                check("pulse_cycle", cyc, e[31:0]);
            end
        end
    end

    initial begin
        logic [31:0] c;
        logic [31:0] n;
        logic [31:0] r;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        increase_btn = 1'b0;
        decrease_btn = 1'b0;

        // reset state
        tick(3);
        check("rst_inc_pulse", {31'd0, duty_inc_pulse}, 32'd0);
        check("rst_dec_pulse", {31'd0, duty_dec_pulse}, 32'd0);
        check("rst_inc_level", {31'd0, inc_level}, 32'd0);
        check("rst_dec_level", {31'd0, dec_level}, 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        tick(3);

        // 1: clean press, single pulse, release latency
        c = cyc;
        increase_btn = 1'b1;
        expect_pulse(1'b0, c + 7);
        tick(5);
        check("s1_level_before_edge6", {31'd0, inc_level}, 32'd0);
        tick(1);
        check("s1_level_after_edge6", {31'd0, inc_level}, 32'd1);
        tick(2);
        increase_btn = 1'b0;
        r = cyc;
        tick(5);
        check("s1_level_5_after_release", {31'd0, inc_level}, 32'd1);
        tick(1);
        check("s1_level_6_after_release", {31'd0, inc_level}, 32'd0);
        tick(20);
        drain("s1_missing_pulses");
        check("s1_state_idle", 32'(dut.state), 32'(IDLE));

        // 2: bouncing decrease button
        decrease_btn = 1'b1;
        tick(1);
        decrease_btn = 1'b0;
        tick(2);
        decrease_btn = 1'b1;
        tick(3);
        decrease_btn = 1'b0;
        tick(2);
        check("s2_no_level_after_glitches", {31'd0, dec_level}, 32'd0);
        c = cyc;
        decrease_btn = 1'b1;
        expect_pulse(1'b1, c + 7);
        tick(5);
        check("s2_level_before_accept", {31'd0, dec_level}, 32'd0);
        tick(1);
        check("s2_level_accepted", {31'd0, dec_level}, 32'd1);
        tick(2);
        decrease_btn = 1'b0;
        tick(20);
        drain("s2_missing_pulses");

        // 3: long hold auto-repeat; release coincides with an expiry
        c = cyc;
        increase_btn = 1'b1;
        expect_pulse(1'b0, c + 7);
        for (int k = 0; k < 6; k++) expect_pulse(1'b0, c + 17 + 32'(5 * k));
        tick(40);
        increase_btn = 1'b0;
        tick(20);
        drain("s3_missing_pulses");

        // 4: lockout by pressing decrease during an increase hold
        c = cyc;
        increase_btn = 1'b1;
        expect_pulse(1'b0, c + 7);
        tick(9);
        decrease_btn = 1'b1;
        tick(16);
        check("s4_state_lockout", 32'(dut.state), 32'(LOCKOUT));
        decrease_btn = 1'b0;
        tick(15);
        check("s4_still_lockout", 32'(dut.state), 32'(LOCKOUT));
        check("s4_dec_level_low", {31'd0, dec_level}, 32'd0);
        check("s4_inc_level_high", {31'd0, inc_level}, 32'd1);
        increase_btn = 1'b0;
        tick(10);
        check("s4_back_to_idle", 32'(dut.state), 32'(IDLE));
        n = cyc;
        increase_btn = 1'b1;
        expect_pulse(1'b0, n + 7);
        tick(8);
        increase_btn = 1'b0;
        tick(20);
        drain("s4_missing_pulses");

        // 5: both pressed on the same edge
        increase_btn = 1'b1;
        decrease_btn = 1'b1;
        tick(15);
        check("s5_state_lockout", 32'(dut.state), 32'(LOCKOUT));
        tick(5);
        increase_btn = 1'b0;
        decrease_btn = 1'b0;
        tick(20);
        check("s5_state_idle", 32'(dut.state), 32'(IDLE));
        drain("s5_missing_pulses");

        // 6: reset during a hold, button kept pressed through release
        c = cyc;
        increase_btn = 1'b1;
        expect_pulse(1'b0, c + 7);
        expect_pulse(1'b0, c + 17);
        tick(17);
        #1 rst = 1'b1;
        #1;
        check("s6_async_inc_pulse", {31'd0, duty_inc_pulse}, 32'd0);
        check("s6_async_inc_level", {31'd0, inc_level}, 32'd0);
        check("s6_async_dec_pulse", {31'd0, duty_dec_pulse}, 32'd0);
        check("s6_async_state", 32'(dut.state), 32'(IDLE));
        tick(3);
        rst = 1'b0;
        r = cyc;
        expect_pulse(1'b0, r + 7);
        tick(8);
        increase_btn = 1'b0;
        tick(20);
        drain("s6_missing_pulses");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_button_conditioner.md
# pwm_button_conditioner

Conditions the two raw duty-adjust push-buttons into clean single-cycle step commands for the PWM generator's duty-cycle register. Each button is synchronized and debounced, and arbitrated so that pressing both buttons produces no command. Holding one button auto-repeats. The outputs connect directly to the generator's increase/decrease inputs, which then need no debouncing of their own.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 2_000_000: number of consecutive cycles the input must stay at a new level before it is accepted (20 ms at 100 MHz). Must be at least 2.
- REPEAT_DELAY_CYCLES, 50_000_000: cycles from the first pulse to the first auto-repeat pulse (500 ms). Must be at least 2.
- REPEAT_RATE_CYCLES, 25_000_000: cycles between later auto-repeat pulses (4 Hz). Must be at least 2.

Ports:
- clk, input, 1: 100 MHz system clock. All logic is on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- increase_btn, input, 1: raw, asynchronous, bouncing button, active high.
- decrease_btn, input, 1: raw, asynchronous, bouncing button, active high.
- duty_inc_pulse, output, 1: one-cycle step-up command, registered.
- duty_dec_pulse, output, 1: one-cycle step-down command, registered.
- inc_level, output, 1: debounced level of increase_btn, registered.
- dec_level, output, 1: debounced level of decrease_btn, registered.

## Operation
Per-button path:
- Each button passes through a 2-flop synchronizer, then a debouncer.
- The debouncer holds a stable level and a counter.
  - When the synchronized value equals the stable level, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and the values still differ, the stable level flips and the counter clears.
- Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
- inc_level and dec_level are the stable levels.

Arbitration FSM (one for the block), with a shared repeat timer that counts down:
- IDLE
  - inc_level=1 and dec_level=0: assert duty_inc_pulse, load timer with REPEAT_DELAY_CYCLES-1, go to INC_HOLD.
  - dec_level=1 and inc_level=0: the symmetric action, go to DEC_HOLD.
  - Both levels high: go to LOCKOUT with no pulse.
- INC_HOLD
  - inc_level=0: go to IDLE. This has priority.
  - dec_level=1: go to LOCKOUT with no pulse.
  - Otherwise the timer decrements. When the timer is 0, assert duty_inc_pulse and reload it with REPEAT_RATE_CYCLES-1.
- DEC_HOLD: symmetric to INC_HOLD.
- LOCKOUT: stays until inc_level=0 and dec_level=0, then goes to IDLE.

General rules:
- duty_inc_pulse and duty_dec_pulse are never high in the same cycle.
- Pulses are asserted for exactly one cycle each.
- The block does not know the duty-cycle limits. The generator saturates at its own bounds.

## Timing
Reset:
- All outputs are 0.
- Synchronizers, stable levels and counters are 0.
- The FSM is in IDLE.
- Reset asserted mid-hold aborts the repeat immediately.
- A button held through reset release is debounced again from 0 and produces a fresh first pulse.

Latency:
- Call the first rising edge that samples a clean new input level edge 1.
- The stable level changes at edge DEBOUNCE_CYCLES+2.
- The first pulse is high for the one cycle following edge DEBOUNCE_CYCLES+3.
- Release is debounced with the same latency.

Repeat timing:
- With the first pulse at edge T0, repeat pulses occur at T0+REPEAT_DELAY_CYCLES, then every REPEAT_RATE_CYCLES.
- The spacing is exact, with no drift.

Edge cases:
- Both levels rising in the same cycle: LOCKOUT, no pulse.
- Release and repeat expiry in the same cycle: no pulse, go to IDLE.

Counter widths: $clog2 of each parameter. Counters never wrap.

## Structure
- Shared package pwm_ctrl_pkg holds:
  - the FSM state enum (IDLE, INC_HOLD, DEC_HOLD, LOCKOUT);
  - the default debounce, delay and rate constants, shared with the PWM generator's top level.
- Sub-module button_debounce contains the synchronizer, counter and stable level, with parameter DEBOUNCE_CYCLES. It is instantiated twice.
- The FSM and repeat timer live in pwm_button_conditioner.

## Test plan
All scenarios use DEBOUNCE=4, DELAY=10, RATE=5.
- Clean press on increase_btn at edge 1, held for 8 cycles, then released:
  - inc_level rises after edge 6;
  - a single duty_inc_pulse follows edge 7;
  - no repeat occurs;
  - inc_level falls 6 edges after release.
- Bounce of 1-cycle and 3-cycle glitches on decrease_btn, then stable high: no pulse until 4 stable cycles have passed, then exactly one duty_dec_pulse.
- Hold increase_btn for 40 cycles: pulses at T0, T0+10, T0+15, T0+20 and onward, each 1 cycle wide.
- Hold increase, then press decrease mid-hold:
  - no further pulses, state is LOCKOUT;
  - releasing only decrease gives no pulse;
  - releasing both returns to IDLE;
  - a new press pulses again.
- Both buttons pressed on the same edge: zero pulses on both outputs for the whole hold.
- Assert rst during INC_HOLD:
  - all outputs are 0 within the reset assertion, asynchronously;
  - with the button still held, the first pulse appears 7 edges after reset release.
